accel_dispatch_ctrl: RTL and testbench
======================================

ACCEL_DISPATCH_CTRL -- requirements
Module: accel_dispatch_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024: maximum WAIT-state cycles before abort; legal range 2..65535.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; asserted when 0.
REQ-004 instr_valid  input  1  decode-stage instruction valid.
REQ-005 is_accel_in  input  1  decode flags a custom accelerator opcode (7'b1111110 / 7'b1111111).
REQ-006 instr_in  input  32  decoded instruction word.
REQ-007 rs1_data_in  input  32  accelerator argument (rs1 ID, zero-extended).
REQ-008 rd_in  input  5  destination register.
REQ-009 flush  input  1  pipeline flush from branch/exception.
REQ-010 accel_done  input  1  single-cycle completion pulse from accelerator.
REQ-011 accel_result  input  32  result; valid when accel_done=1.
REQ-012 stall_out  output  1  hold IF/ID and decode.
REQ-013 accel_start  output  1  single-cycle launch pulse.
REQ-014 accel_cmd  output  32  latched instruction word, stable from ISSUE until return to IDLE.
REQ-015 accel_arg  output  32  latched rs1_data_in, same stability as accel_cmd.
REQ-016 accel_busy  output  1  high in any state other than IDLE.
REQ-017 wb_valid  output  1  single-cycle register write-back strobe.
REQ-018 wb_rd  output  5  write-back destination.
REQ-019 wb_data  output  32  write-back data.
REQ-020 err_timeout  output  1  sticky timeout flag.

Function
REQ-021 FSM states: IDLE, ISSUE, WAIT, WB, encoded in 2 bits.
REQ-022 Dispatch condition: state IDLE and instr_valid=1 and is_accel_in=1 and flush=0.
- On the next edge: latch instr_in, rs1_data_in, rd_in; go to ISSUE.
REQ-023 stall_out is combinational: 1 when state!=IDLE, or when the dispatch condition is true; 0 otherwise.
- Stall therefore holds the same cycle the accel instruction appears in decode.
REQ-024 ISSUE lasts exactly one cycle, with accel_start=1.
- Next state: WB if accel_done=1 in that cycle; otherwise WAIT.
REQ-025 WAIT: a 16-bit counter cleared on entry increments each cycle.
- accel_done=1: capture accel_result, go to WB.
- Counter reaching TIMEOUT_CYCLES-1 without done: set err_timeout, capture 32'hFFFF_FFFF, go to WB.
- accel_done and timeout in the same cycle: done wins and err_timeout is not set.
REQ-026 WB lasts exactly one cycle, with wb_valid=1, wb_rd=latched rd, wb_data=captured value; then IDLE.
REQ-027 Latched rd=0: wb_valid stays 0 in WB; state sequencing is unchanged.
REQ-028 flush is ignored when it is not asserted in IDLE, ISSUE or WAIT.
- flush in IDLE: blocks dispatch that cycle.
- flush in ISSUE or WAIT: does not abort the accelerator; sets a kill flag that suppresses wb_valid in the following WB.
- The kill flag clears on return to IDLE.
REQ-029 accel_done is ignored in IDLE and WB; no capture and no state change.
REQ-030 err_timeout clears only on reset.
REQ-031 Back-to-back accel instructions: the second is dispatched only from IDLE, so the minimum issue spacing is 3 cycles (ISSUE, WB, IDLE).
REQ-032 wb_rd and wb_data are held at their last values when wb_valid=0.

Reset
REQ-033 reset=0 forces immediately, independent of clk:
- state=IDLE, counter=0, kill=0, err_timeout=0;
- accel_start=0, wb_valid=0, wb_rd=0, wb_data=0, accel_cmd=0, accel_arg=0.
REQ-034 Reset asserted mid-operation (ISSUE or WAIT) abandons the command; no write-back occurs after reset release.
REQ-035 The first dispatch is possible on the first rising edge with reset=1.

Verification
REQ-036 Normal operation:
- Stimulus: instr 32'h0000_0A7F, rs1_data=5, rd=3; accel_done 4 cycles after start with result 32'h1234.
- Response: one start pulse; accel_arg=5; wb_valid one cycle with rd=3, data=32'h1234; stall high from the decode cycle through WB.
REQ-037 Same-cycle done:
- Stimulus: accel_done during ISSUE.
- Response: WAIT skipped; WB on the next cycle.
REQ-038 Timeout:
- Stimulus: TIMEOUT_CYCLES=8, accel_done never asserted.
- Response: err_timeout=1 after 8 WAIT cycles; wb_data=32'hFFFF_FFFF; FSM returns to IDLE.
REQ-039 Flush:
- Stimulus: flush during WAIT, then done.
- Response: wb_valid stays 0; next accel instruction dispatches normally.
- Stimulus: flush in IDLE alongside an accel instruction.
- Response: no start pulse.
REQ-040 rd=0 and reset:
- Stimulus: accel instruction with rd=0.
- Response: no wb_valid.
- Stimulus: reset pulsed during WAIT.
- Response: all outputs 0 immediately; no later write-back.

Source files
------------

// File: rtl/accel_dispatch_ctrl.sv
// Dispatch controller for a custom accelerator hanging off the decode stage.
// It stalls decode, launches the command, waits for completion or timeout, and writes the result back.
module accel_dispatch_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic        is_accel_in,
  input  logic [31:0] instr_in,
  input  logic [31:0] rs1_data_in,
  input  logic [4:0]  rd_in,
  input  logic        flush,
  input  logic        accel_done,
  input  logic [31:0] accel_result,
  output logic        stall_out,
  output logic        accel_start,
  output logic [31:0] accel_cmd,
  output logic [31:0] accel_arg,
  output logic        accel_busy,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        err_timeout
);

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    WB    = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [15:0] wait_count;
  logic        kill;
  logic [4:0]  rd_q;

  logic        dispatch;
  logic        timeout_hit;
  logic        enter_wb;
  logic        wb_enable;
  logic [31:0] wb_value;

  // Next-state and decode of the write-back decision
  always_comb begin
    dispatch    = 1'b0;
    timeout_hit = 1'b0;
    state_next  = state;
    enter_wb    = 1'b0;
    wb_enable   = 1'b0;
    wb_value    = 32'hFFFF_FFFF;

    dispatch    = (state == IDLE) && instr_valid && is_accel_in && !flush;
    timeout_hit = (state == WAIT) && !accel_done && (wait_count == TIMEOUT_LAST);

    case (state)
      IDLE:    if (dispatch) state_next = ISSUE;
      ISSUE:   state_next = accel_done ? WB : WAIT;
      WAIT:    if (accel_done || timeout_hit) state_next = WB;
      WB:      state_next = IDLE;
      default: state_next = IDLE;
    endcase

    enter_wb = (state == ISSUE || state == WAIT) && (state_next == WB);
    if (accel_done) wb_value = accel_result;
    // A flush arriving on the very cycle we leave for WB still kills the write
    wb_enable = enter_wb && (rd_q != 5'd0) && !kill && !flush;
  end

  assign stall_out   = (state != IDLE) || dispatch;
  assign accel_start = (state == ISSUE);
  assign accel_busy  = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      accel_cmd <= 32'd0;
      accel_arg <= 32'd0;
      rd_q      <= 5'd0;
    end else if (dispatch) begin
      accel_cmd <= instr_in;
      accel_arg <= rs1_data_in;
      rd_q      <= rd_in;
    end
  end

  // Wait counter restarts from zero every time ISSUE hands over to WAIT
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_count <= 16'd0;
    end else if (state == ISSUE) begin
      wait_count <= 16'd0;
    end else if (state == WAIT) begin
      wait_count <= wait_count + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      kill <= 1'b0;
    end else if (state == WB || state == IDLE) begin
      kill <= 1'b0;
    end else if (flush) begin
      kill <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           err_timeout <= 1'b0;
    else if (timeout_hit) err_timeout <= 1'b1;
  end

  // Write-back registers only move on an effective write, so they hold otherwise
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_valid <= 1'b0;
      wb_rd    <= 5'd0;
      wb_data  <= 32'd0;
    end else begin
      wb_valid <= wb_enable;
      if (wb_enable) begin
        wb_rd   <= rd_q;
        wb_data <= wb_value;
      end
    end
  end

endmodule

// File: tb/tb_accel_dispatch_ctrl.sv
// Directed self-checking bench for accel_dispatch_ctrl with a short timeout.
module tb_accel_dispatch_ctrl;

  logic        clk;
  logic        reset;
  logic        instr_valid;
  logic        is_accel_in;
  logic [31:0] instr_in;
  logic [31:0] rs1_data_in;
  logic [4:0]  rd_in;
  logic        flush;
  logic        accel_done;
  logic [31:0] accel_result;
  logic        stall_out;
  logic        accel_start;
  logic [31:0] accel_cmd;
  logic [31:0] accel_arg;
  logic        accel_busy;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        err_timeout;

  int tests_run    = 0;
  int tests_failed = 0;

  accel_dispatch_ctrl #(.TIMEOUT_CYCLES(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .instr_valid  (instr_valid),
    .is_accel_in  (is_accel_in),
    .instr_in     (instr_in),
    .rs1_data_in  (rs1_data_in),
    .rd_in        (rd_in),
    .flush        (flush),
    .accel_done   (accel_done),
    .accel_result (accel_result),
    .stall_out    (stall_out),
    .accel_start  (accel_start),
    .accel_cmd    (accel_cmd),
    .accel_arg    (accel_arg),
    .accel_busy   (accel_busy),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .err_timeout  (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Inputs change on the falling edge; checks follow 1ns later, well before the rising edge
  task automatic applyStimulus(input logic v, input logic a, input logic [31:0] instr,
                               input logic [31:0] rs1, input logic [4:0] rd, input logic fl,
                               input logic dn, input logic [31:0] res);
    @(negedge clk);
    instr_valid  = v;
    is_accel_in  = a;
    instr_in     = instr;
    rs1_data_in  = rs1;
    rd_in        = rd;
    flush        = fl;
    accel_done   = dn;
    accel_result = res;
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic doneCycle(input logic [31:0] res);
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1, res);
  endtask

  task automatic dispatchCycle(input logic [31:0] instr, input logic [31:0] rs1, input logic [4:0] rd);
    applyStimulus(1'b1, 1'b1, instr, rs1, rd, 1'b0, 1'b0, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    instr_valid = 0; is_accel_in = 0; instr_in = 0; rs1_data_in = 0;
    rd_in = 0; flush = 0; accel_done = 0; accel_result = 0;
    #2 reset = 1'b0;
    #1;
    checkOutput("rst_busy",   accel_busy,  0);
    checkOutput("rst_start",  accel_start, 0);
    checkOutput("rst_wbv",    wb_valid,    0);
    checkOutput("rst_wbrd",   wb_rd,       0);
    checkOutput("rst_wbdata", wb_data,     0);
    checkOutput("rst_cmd",    accel_cmd,   0);
    checkOutput("rst_arg",    accel_arg,   0);
    checkOutput("rst_err",    err_timeout, 0);
    checkOutput("rst_stall",  stall_out,   0);
    @(negedge clk);
    reset = 1'b1;

    // Normal operation: done four cycles after start
    dispatchCycle(32'h0000_0A7F, 32'd5, 5'd3);
    checkOutput("n_stall_dec", stall_out, 1);
    checkOutput("n_start_dec", accel_start, 0);
    idleCycle();
    checkOutput("n_start", accel_start, 1);
    checkOutput("n_cmd",   accel_cmd, 32'h0000_0A7F);
    checkOutput("n_arg",   accel_arg, 5);
    checkOutput("n_stall_iss", stall_out, 1);
    for (int i = 1; i <= 3; i++) begin
      idleCycle();
      checkOutput("n_wait_start", accel_start, 0);
      checkOutput("n_wait_stall", stall_out, 1);
      checkOutput("n_wait_wbv",   wb_valid, 0);
    end
    doneCycle(32'h1234);
    checkOutput("n_wait4_busy", accel_busy, 1);
    idleCycle();
    checkOutput("n_wbv",   wb_valid, 1);
    checkOutput("n_wbrd",  wb_rd, 3);
    checkOutput("n_wbd",   wb_data, 32'h1234);
    checkOutput("n_stall_wb", stall_out, 1);
    idleCycle();
    checkOutput("n_idle_wbv",  wb_valid, 0);
    checkOutput("n_idle_busy", accel_busy, 0);
    checkOutput("n_idle_stall", stall_out, 0);
    checkOutput("n_hold_wbd",  wb_data, 32'h1234);
    checkOutput("n_hold_wbrd", wb_rd, 3);

    // Same-cycle done: WAIT skipped
    dispatchCycle(32'h0000_0002, 32'd1, 5'd7);
    doneCycle(32'h0000_AAAA);
    checkOutput("s_start", accel_start, 1);
    idleCycle();
    checkOutput("s_wbv",  wb_valid, 1);
    checkOutput("s_wbd",  wb_data, 32'h0000_AAAA);
    checkOutput("s_wbrd", wb_rd, 7);
    idleCycle();
    checkOutput("s_idle", accel_busy, 0);

    // Done on the last allowed WAIT cycle beats the timeout
    dispatchCycle(32'h0000_0003, 32'd2, 5'd4);
    idleCycle();
    for (int i = 1; i <= 7; i++) idleCycle();
    doneCycle(32'h0000_5555);
    checkOutput("dt_busy8", accel_busy, 1);
    idleCycle();
    checkOutput("dt_wbv", wb_valid, 1);
    checkOutput("dt_wbd", wb_data, 32'h0000_5555);
    checkOutput("dt_err", err_timeout, 0);
    idleCycle();

    // Timeout after eight WAIT cycles
    dispatchCycle(32'h0000_0004, 32'd3, 5'd9);
    idleCycle();
    for (int i = 1; i <= 8; i++) begin
      idleCycle();
      checkOutput("t_wait_err", err_timeout, 0);
      checkOutput("t_wait_wbv", wb_valid, 0);
    end
    idleCycle();
    checkOutput("t_err",  err_timeout, 1);
    checkOutput("t_wbv",  wb_valid, 1);
    checkOutput("t_wbd",  wb_data, 32'hFFFF_FFFF);
    checkOutput("t_wbrd", wb_rd, 9);
    idleCycle();
    checkOutput("t_idle", accel_busy, 0);
    checkOutput("t_sticky", err_timeout, 1);

    // Flush during WAIT suppresses the write-back
    dispatchCycle(32'h0000_0005, 32'd4, 5'd5);
    idleCycle();
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b1, 1'b0, 32'd0);
    checkOutput("f_wait_busy", accel_busy, 1);
    doneCycle(32'h0000_7777);
    idleCycle();
    checkOutput("f_wb_busy", accel_busy, 1);
    checkOutput("f_wbv",  wb_valid, 0);
    checkOutput("f_wbd",  wb_data, 32'hFFFF_FFFF);
    idleCycle();
    checkOutput("f_idle", accel_busy, 0);
    dispatchCycle(32'h0000_0006, 32'd6, 5'd6);
    doneCycle(32'h0000_6666);
    idleCycle();
    checkOutput("f_next_wbv", wb_valid, 1);
    checkOutput("f_next_wbd", wb_data, 32'h0000_6666);
    idleCycle();

    // Flush in IDLE blocks dispatch
    applyStimulus(1'b1, 1'b1, 32'h0000_0007, 32'd7, 5'd8, 1'b1, 1'b0, 32'd0);
    checkOutput("fi_stall", stall_out, 0);
    idleCycle();
    checkOutput("fi_start", accel_start, 0);
    checkOutput("fi_busy",  accel_busy, 0);

    // Done in IDLE is ignored
    doneCycle(32'h0000_DEAD);
    idleCycle();
    checkOutput("di_busy", accel_busy, 0);
    checkOutput("di_wbv",  wb_valid, 0);
    checkOutput("di_wbd",  wb_data, 32'h0000_6666);

    // rd = 0 never strobes write-back
    dispatchCycle(32'h0000_0008, 32'd8, 5'd0);
    doneCycle(32'h0000_0BAD);
    idleCycle();
    checkOutput("r0_busy", accel_busy, 1);
    checkOutput("r0_wbv",  wb_valid, 0);
    checkOutput("r0_wbd",  wb_data, 32'h0000_6666);
    checkOutput("r0_wbrd", wb_rd, 6);
    idleCycle();

    // Reset in WAIT clears everything immediately
    dispatchCycle(32'h0000_ABCD, 32'd9, 5'd2);
    idleCycle();
    idleCycle();
    idleCycle();
    reset = 1'b0;
    #1;
    checkOutput("rw_busy",  accel_busy, 0);
    checkOutput("rw_start", accel_start, 0);
    checkOutput("rw_cmd",   accel_cmd, 0);
    checkOutput("rw_arg",   accel_arg, 0);
    checkOutput("rw_wbrd",  wb_rd, 0);
    checkOutput("rw_wbd",   wb_data, 0);
    checkOutput("rw_err",   err_timeout, 0);
    checkOutput("rw_stall", stall_out, 0);
    doneCycle(32'h0000_BEEF);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      doneCycle(32'h0000_BEEF);
      checkOutput("rw_post_wbv",  wb_valid, 0);
      checkOutput("rw_post_busy", accel_busy, 0);
    end

    // Dispatch on the first edge after reset release
    idleCycle();
    reset = 1'b0;
    #1;
    dispatchCycle(32'h0000_0011, 32'd1, 5'd1);
    reset = 1'b1;
    #1;
    checkOutput("rr_stall", stall_out, 1);
    doneCycle(32'h0000_1111);
    checkOutput("rr_start", accel_start, 1);
    idleCycle();
    checkOutput("rr_wbv", wb_valid, 1);
    checkOutput("rr_wbd", wb_data, 32'h0000_1111);
    idleCycle();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
